// File: rtl/router_ingress_ctrl.sv
// Ingress controller of the 1x3 router: decodes packet headers, steers bytes into one of
// three output FIFOs, checks packet parity and drops undeliverable packets.
module router_ingress_ctrl #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] data_in,
  output logic       in_ready,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  output logic [2:0] write_enb,
  output logic [7:0] data_out,
  output logic       lfd_state,
  output logic       busy,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       drop_err
);

  typedef enum logic [2:0] {
    StDecode,
    StWaitEmpty,
    StLoadFirst,
    StLoadData,
    StLoadParity,
    StDrop
  } state_e;

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [7:0] hdr_q;
  logic [1:0] addr_q;
  logic [5:0] remaining_q;
  logic [7:0] parity_q;
  logic [6:0] drop_cnt_q;
  logic [7:0] wait_cnt_q;

  logic       accept;
  logic [2:0] addr_oh;
  // Padded so that destination 3 indexes a defined (never-asserted) flag.
  logic [3:0] full_ext;
  logic [3:0] empty_ext;

  assign addr_oh   = 3'b001 << addr_q;
  assign full_ext  = {1'b0, fifo_full};
  assign empty_ext = {1'b0, fifo_empty};

  always_comb begin
    in_ready  = 1'b0;
    write_enb = 3'b000;
    lfd_state = 1'b0;
    data_out  = data_in;
    unique case (state_q)
      StDecode: begin
        in_ready = 1'b1;
        data_out = 8'h00;
      end
      StWaitEmpty: ;
      StLoadFirst: begin
        write_enb = addr_oh;
        lfd_state = 1'b1;
        data_out  = hdr_q;
      end
      StLoadData: begin
        in_ready = !full_ext[addr_q];
        if (in_valid && !full_ext[addr_q]) write_enb = addr_oh;
      end
      StLoadParity, StDrop: in_ready = 1'b1;
      default: ;
    endcase
    busy   = !in_ready;
    accept = in_valid && in_ready;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StDecode;
      hdr_q       <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      parity_q    <= '0;
      drop_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      parity_err  <= 1'b0;
      pkt_done    <= 1'b0;
      drop_err    <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      drop_err <= 1'b0;
      unique case (state_q)
        StDecode: begin
          if (accept) begin
            hdr_q       <= data_in;
            addr_q      <= data_in[1:0];
            remaining_q <= data_in[7:2];
            parity_q    <= data_in;
            wait_cnt_q  <= '0;
            if (data_in[1:0] == 2'd3) begin
              state_q    <= StDrop;
              drop_cnt_q <= {1'b0, data_in[7:2]} + 7'd1;
            end else if (empty_ext[data_in[1:0]]) begin
              state_q <= StLoadFirst;
            end else begin
              state_q <= StWaitEmpty;
            end
          end
        end
        StWaitEmpty: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          // A draining FIFO wins over an expiring timeout in the same cycle.
          if (empty_ext[addr_q]) begin
            state_q <= StLoadFirst;
          end else if (wait_cnt_q == WaitLast) begin
            state_q    <= StDrop;
            drop_cnt_q <= {1'b0, remaining_q} + 7'd1;
          end
        end
        StLoadFirst: state_q <= (remaining_q == 6'd0) ? StLoadParity : StLoadData;
        StLoadData: begin
          if (accept) begin
            parity_q    <= parity_q ^ data_in;
            remaining_q <= remaining_q - 6'd1;
            if (remaining_q == 6'd1) state_q <= StLoadParity;
          end
        end
        StLoadParity: begin
          if (accept) begin
            parity_err <= (data_in != parity_q);
            pkt_done   <= 1'b1;
            state_q    <= StDecode;
          end
        end
        StDrop: begin
          if (accept) begin
            drop_cnt_q <= drop_cnt_q - 7'd1;
            if (drop_cnt_q == 7'd1) begin
              state_q  <= StDecode;
              drop_err <= 1'b1;
            end
          end
        end
        default: state_q <= StDecode;
      endcase
    end
  end

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// Bench for router_ingress_ctrl: directed scenarios then random traffic, all checked
// against a packet-position reference model.
module tb_router_ingress_ctrl;

  localparam int TIMEOUT = 30;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] fifo_full = 3'b000;
  logic [2:0] fifo_empty = 3'b111;
  logic       in_ready, lfd_state, busy, pkt_done, parity_err, drop_err;
  logic [2:0] write_enb;
  logic [7:0] data_out;

  router_ingress_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .in_ready  (in_ready),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .write_enb (write_enb),
    .data_out  (data_out),
    .lfd_state (lfd_state),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .parity_err(parity_err),
    .drop_err  (drop_err)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;
  int obs_writes = 0;
  int obs_drops = 0;
  int obs_done = 0;

  // Reference model: where we are inside the current packet.
  bit         m_active = 0;   // a header has been taken and the packet is not finished
  bit         m_drop = 0;     // remaining bytes of this packet are discarded
  bit         m_waiting = 0;  // header held until its FIFO is empty
  bit         m_go = 0;       // header is written this cycle
  int         m_pos = 0;      // packet bytes accepted so far (header counts as 1)
  int         m_len = 0;
  int         m_waited = 0;
  int         m_drop_left = 0;
  logic [1:0] m_dst = 2'd0;
  logic [7:0] m_hdr = 8'h00;
  logic [7:0] m_xor = 8'h00;
  logic       e_pd = 1'b0;
  logic       e_de = 1'b0;
  logic       e_pe = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_drop = 0; m_waiting = 0; m_go = 0;
    m_pos = 0; m_len = 0; m_waited = 0; m_drop_left = 0;
    e_pd = 0; e_de = 0; e_pe = 0;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] f,
                       input logic [2:0] e, input logic r, output logic acc);
    logic       er, el;
    logic [2:0] ew, oh;
    logic [7:0] ed;
    logic [3:0] fx, ex;
    @(negedge clock);
    in_valid = v; data_in = d; fifo_full = f; fifo_empty = e; reset = r;
    #1;
    fx = {1'b0, f};
    ex = {1'b0, e};
    oh = 3'(1 << m_dst);
    if (!m_active || m_drop) er = 1'b1;
    else if (m_waiting || m_go) er = 1'b0;
    else if (m_pos <= m_len) er = !fx[m_dst];
    else er = 1'b1;
    ew = 3'b000;
    if (m_go) ew = oh;
    else if (m_active && !m_drop && !m_waiting && m_pos <= m_len && v && !fx[m_dst]) ew = oh;
    el = m_go;
    ed = !m_active ? 8'h00 : (m_go ? m_hdr : d);
    check("in_ready", in_ready, er);
    check("busy", busy, !er);
    check("write_enb", write_enb, ew);
    check("lfd_state", lfd_state, el);
    check("data_out", data_out, ed);
    check("pkt_done", pkt_done, e_pd);
    check("drop_err", drop_err, e_de);
    check("parity_err", parity_err, e_pe);
    if (write_enb != 3'b000) obs_writes++;
    if (drop_err) obs_drops++;
    if (pkt_done) obs_done++;
    acc = v && er;
    @(posedge clock);
    if (r) begin
      model_reset();
    end else begin
      e_pd = 0;
      e_de = 0;
      if (!m_active) begin
        if (acc) begin
          m_active = 1; m_hdr = d; m_dst = d[1:0]; m_len = int'(d[7:2]);
          m_xor = d; m_pos = 1; m_waited = 0;
          if (d[1:0] == 2'd3) begin
            m_drop = 1; m_drop_left = m_len + 1;
          end else if (ex[d[1:0]]) m_go = 1;
          else m_waiting = 1;
        end
      end else if (m_waiting) begin
        if (ex[m_dst]) begin
          m_waiting = 0; m_go = 1;
        end else if (m_waited == TIMEOUT - 1) begin
          m_waiting = 0; m_drop = 1; m_drop_left = m_len + 1;
        end else m_waited++;
      end else if (m_go) begin
        m_go = 0;
      end else if (m_drop) begin
        if (acc) begin
          m_drop_left--;
          if (m_drop_left == 0) begin
            m_active = 0; m_drop = 0; e_de = 1;
          end
        end
      end else if (m_pos <= m_len) begin
        if (acc) begin
          m_xor = m_xor ^ d; m_pos++;
        end
      end else if (acc) begin
        e_pe = (d != m_xor); e_pd = 1; m_active = 0;
      end
    end
  endtask

  // Present a byte until the model says it is taken, within a cycle budget.
  task automatic send(input logic [7:0] d, input logic [2:0] f, input logic [2:0] e);
    logic acc;
    int   n = 0;
    do begin
      drive(1'b1, d, f, e, 1'b0, acc);
      n++;
    end while (!acc && n < 60);
    if (!acc) begin
      mismatched++;
      $error("FAIL send_bound: byte %0h not accepted after %0d cycles", d, n);
    end
  endtask

  task automatic idle(input logic [2:0] e);
    logic acc;
    drive(1'b0, 8'h00, 3'b000, e, 1'b0, acc);
  endtask

  initial begin
    logic       acc;
    logic [7:0] d;
    logic [2:0] f, e;
    repeat (2) @(posedge clock);
    model_reset();
    drive(1'b0, 8'h00, 3'b000, 3'b111, 1'b1, acc);
    idle(3'b111);

    // Good packet to FIFO 1.
    obs_writes = 0; obs_done = 0;
    send(8'h0D, 3'b000, 3'b111); send(8'h11, 3'b000, 3'b111);
    send(8'h22, 3'b000, 3'b111); send(8'h33, 3'b000, 3'b111);
    send(8'h0D, 3'b000, 3'b111); idle(3'b111);
    check("s1_writes", 8'(obs_writes), 8'd4);
    check("s1_done", 8'(obs_done), 8'd1);

    // Same packet, bad parity.
    send(8'h0D, 3'b000, 3'b111); send(8'h11, 3'b000, 3'b111);
    send(8'h22, 3'b000, 3'b111); send(8'h33, 3'b000, 3'b111);
    send(8'h00, 3'b000, 3'b111); idle(3'b111); idle(3'b111);
    check("s2_perr_held", parity_err, 1'b1);

    // Backpressure from FIFO 1 for two cycles.
    obs_writes = 0;
    send(8'h0D, 3'b000, 3'b111); send(8'h11, 3'b000, 3'b111);
    drive(1'b1, 8'h22, 3'b010, 3'b111, 1'b0, acc);
    drive(1'b1, 8'h22, 3'b010, 3'b111, 1'b0, acc);
    send(8'h22, 3'b000, 3'b111); send(8'h33, 3'b000, 3'b111);
    send(8'h0D, 3'b000, 3'b111); idle(3'b111);
    check("s3_writes", 8'(obs_writes), 8'd4);
    check("s3_perr", parity_err, 1'b0);

    // Invalid destination is swallowed.
    obs_writes = 0; obs_drops = 0;
    send(8'h07, 3'b000, 3'b111); send(8'hAA, 3'b000, 3'b111);
    send(8'hBB, 3'b000, 3'b111); idle(3'b111);
    check("s4_writes", 8'(obs_writes), 8'd0);
    check("s4_drops", 8'(obs_drops), 8'd1);

    // Destination busy, then released; then never released.
    drive(1'b1, 8'h02, 3'b000, 3'b000, 1'b0, acc);
    repeat (4) drive(1'b0, 8'h00, 3'b000, 3'b000, 1'b0, acc);
    send(8'h02, 3'b000, 3'b100); idle(3'b111);
    obs_drops = 0; obs_writes = 0;
    send(8'h02, 3'b000, 3'b000); send(8'h5A, 3'b000, 3'b000);
    idle(3'b000); idle(3'b000);
    check("s5_timeout_drops", 8'(obs_drops), 8'd1);
    check("s5_timeout_writes", 8'(obs_writes), 8'd0);

    // Reset in mid-packet.
    send(8'h0D, 3'b000, 3'b111); send(8'h11, 3'b000, 3'b111); send(8'h22, 3'b000, 3'b111);
    drive(1'b1, 8'h33, 3'b000, 3'b111, 1'b1, acc);
    idle(3'b111);
    send(8'h0D, 3'b000, 3'b111); send(8'h11, 3'b000, 3'b111);
    send(8'h22, 3'b000, 3'b111); send(8'h33, 3'b000, 3'b111);
    send(8'h0D, 3'b000, 3'b111); idle(3'b111);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if (!m_active) d = {6'($urandom_range(0, 5)), 2'($urandom_range(0, 3))};
      else if (!m_drop && !m_waiting && !m_go && m_pos > m_len && $urandom_range(0, 1) == 0)
        d = m_xor;
      else d = 8'($urandom);
      f = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      e = (i % 500 < 380) ? 3'($urandom) : 3'b000;
      drive($urandom_range(0, 3) != 0, d, f, e, $urandom_range(0, 499) == 0, acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
